// File: rtl/jtframe_mr_ddrmux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtframe_mr_ddrmux: two-requester burst arbiter for the DDRAM port    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module jtframe_mr_ddrmux #(
  parameter int FIXED_PRIO = 0,
  parameter int AW         = 29
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] a_addr,
  input  logic          a_rd,
  input  logic          a_wr,
  input  logic [7:0]    a_burst,
  input  logic [63:0]   a_din,
  input  logic [7:0]    a_be,
  output logic [63:0]   a_dout,
  output logic          a_dout_ok,
  output logic          a_din_ok,
  output logic          a_done,
  input  logic [AW-1:0] b_addr,
  input  logic          b_rd,
  input  logic          b_wr,
  input  logic [7:0]    b_burst,
  input  logic [63:0]   b_din,
  input  logic [7:0]    b_be,
  output logic [63:0]   b_dout,
  output logic          b_dout_ok,
  output logic          b_din_ok,
  output logic          b_done,
  output logic          ddram_clk,
  input  logic          ddram_busy,
  output logic [7:0]    ddram_burstcnt,
  output logic [AW-1:0] ddram_addr,
  input  logic [63:0]   ddram_dout,
  input  logic          ddram_dout_ready,
  output logic          ddram_rd,
  output logic [63:0]   ddram_din,
  output logic [7:0]    ddram_be,
  output logic          ddram_we
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CMD  = 2'd1,
    RD_DATA = 2'd2,
    WR_DATA = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          gnt_b_q, gnt_b_d;
  logic          rr_b_q, rr_b_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    burst_q, burst_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    be_q, be_d;
  logic          rd_q, rd_d;
  logic          we_q, we_d;
  logic          a_done_q, a_done_d;
  logic          b_done_q, b_done_d;

  logic          a_req, b_req, sel_b, sel_rd, last_beat, rd_beat, wr_beat;
  logic [7:0]    sel_burst;

  assign a_req     = a_rd | a_wr;
  assign b_req     = b_rd | b_wr;
  // B wins only when A is silent, or on a tie when round-robin points at B
  assign sel_b     = b_req && (!a_req || ((FIXED_PRIO == 0) && rr_b_q));
  assign sel_rd    = sel_b ? b_rd : a_rd;
  assign sel_burst = sel_b ? b_burst : a_burst;
  assign last_beat = (cnt_q == burst_q - 8'd1);
  assign rd_beat   = (state_q == RD_DATA) && ddram_dout_ready;
  assign wr_beat   = (state_q == WR_DATA) && !ddram_busy;

  always_comb begin
    state_d  = state_q;
    gnt_b_d  = gnt_b_q;
    rr_b_d   = rr_b_q;
    cnt_d    = cnt_q;
    burst_d  = burst_q;
    addr_d   = addr_q;
    be_d     = be_q;
    rd_d     = rd_q;
    we_d     = we_q;
    a_done_d = 1'b0;
    b_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        // The done cycle is skipped so a request still up from the finished transaction is not re-granted
        if ((a_req || b_req) && !a_done_q && !b_done_q) begin
          gnt_b_d = sel_b;
          rr_b_d  = !sel_b;
          addr_d  = sel_b ? b_addr : a_addr;
          be_d    = sel_b ? b_be : a_be;
          burst_d = (sel_burst == 8'd0) ? 8'd1 : sel_burst;
          cnt_d   = 8'd0;
          if (sel_rd) begin
            state_d = RD_CMD;
            rd_d    = 1'b1;
          end else begin
            state_d = WR_DATA;
            we_d    = 1'b1;
          end
        end
      end
      RD_CMD: begin
        if (!ddram_busy) begin
          rd_d    = 1'b0;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (ddram_dout_ready) begin
          if (last_beat) begin
            state_d  = IDLE;
            cnt_d    = 8'd0;
            a_done_d = !gnt_b_q;
            b_done_d = gnt_b_q;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      WR_DATA: begin
        if (!ddram_busy) begin
          if (last_beat) begin
            state_d  = IDLE;
            we_d     = 1'b0;
            cnt_d    = 8'd0;
            a_done_d = !gnt_b_q;
            b_done_d = gnt_b_q;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_b_q  <= 1'b0;
      rr_b_q   <= 1'b0;
      cnt_q    <= 8'd0;
      burst_q  <= 8'd0;
      addr_q   <= '0;
      be_q     <= 8'd0;
      rd_q     <= 1'b0;
      we_q     <= 1'b0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_b_q  <= gnt_b_d;
      rr_b_q   <= rr_b_d;
      cnt_q    <= cnt_d;
      burst_q  <= burst_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      a_done_q <= a_done_d;
      b_done_q <= b_done_d;
    end
  end

  assign ddram_clk      = clk;
  assign ddram_rd       = rd_q;
  assign ddram_we       = we_q;
  assign ddram_addr     = addr_q;
  assign ddram_burstcnt = burst_q;
  assign ddram_be       = be_q;
  assign ddram_din      = gnt_b_q ? b_din : a_din;

  assign a_dout    = ddram_dout;
  assign b_dout    = ddram_dout;
  assign a_dout_ok = rd_beat && !gnt_b_q;
  assign b_dout_ok = rd_beat && gnt_b_q;
  assign a_din_ok  = wr_beat && !gnt_b_q;
  assign b_din_ok  = wr_beat && gnt_b_q;
  assign a_done    = a_done_q;
  assign b_done    = b_done_q;
endmodule
`default_nettype wire
